// File: rtl/nbit_stream_demux_pkg.sv
// Shared definitions for the handshaked stream demux: mode encoding,
// default sizing and the channel-count helper.
package nbit_stream_demux_pkg;

  typedef enum logic {
    MODE_UNICAST   = 1'b0,
    MODE_BROADCAST = 1'b1
  } demux_mode_e;

  localparam int DEF_SELECT_WIDTH = 3;
  localparam int DEF_DATA_WIDTH   = 32;

  function automatic int chan_count(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/nbit_stream_demux_if.sv
// Producer-side and consumer-side handshake bundle for nbit_stream_demux.
// The slave modport is the demux itself; master is whoever drives it.
interface nbit_stream_demux_if
  import nbit_stream_demux_pkg::*;
#(
  parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
);
  localparam int N = chan_count(SELECT_WIDTH);

  logic [DATA_WIDTH-1:0]   InData;
  logic [SELECT_WIDTH-1:0] InSel;
  logic                    InBcast;
  logic [N-1:0]            InMask;
  logic                    InValid;
  logic                    InReady;
  logic [DATA_WIDTH-1:0]   OutData;
  logic [N-1:0]            OutValid;
  logic [N-1:0]            OutReady;
  logic                    Busy;
  logic                    Dropped;

  modport slave (
    input  InData, InSel, InBcast, InMask, InValid, OutReady,
    output InReady, OutData, OutValid, Busy, Dropped
  );

  modport master (
    output InData, InSel, InBcast, InMask, InValid, OutReady,
    input  InReady, OutData, OutValid, Busy, Dropped
  );

endinterface

// File: rtl/nbit_stream_demux_decoder.sv
// Combinational binary-to-one-hot decoder, shared with other address
// decoders in the datapath.
module nbit_onehot_decoder #(
  parameter int SELECT_WIDTH = 3
) (
  input  logic [SELECT_WIDTH-1:0]      sel,
  output logic [(1<<SELECT_WIDTH)-1:0] onehot
);
  localparam int N = 1 << SELECT_WIDTH;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++)
      if (sel == SELECT_WIDTH'(i)) onehot[i] = 1'b1;
  end

endmodule

// File: rtl/nbit_stream_demux.sv
// Registered 1-to-N stream demux: holds one word until every addressed
// channel has handshaked; unicast via InSel or broadcast via InMask.
module nbit_stream_demux
  import nbit_stream_demux_pkg::*;
#(
  parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  nbit_stream_demux_if.slave bus
);
  localparam int N = chan_count(SELECT_WIDTH);

  logic [N-1:0]          pending;
  logic [N-1:0]          sel_onehot;
  logic [N-1:0]          dest;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  drop_reg;
  logic                  done;
  logic                  accept;
  logic                  is_bcast;

  nbit_onehot_decoder #(.SELECT_WIDTH(SELECT_WIDTH)) u_dec (
    .sel    (bus.InSel),
    .onehot (sel_onehot)
  );

  assign is_bcast = (demux_mode_e'(bus.InBcast) == MODE_BROADCAST);
  assign dest     = is_bcast ? bus.InMask : sel_onehot;

  // Done lets the last handshakes of the held word and the next load share an edge.
  assign done        = ((pending & ~bus.OutReady) == '0);
  assign bus.InReady = ~reset & done;
  assign accept      = bus.InValid & bus.InReady;

  assign bus.OutValid = pending;
  assign bus.OutData  = data_reg;
  assign bus.Busy     = |pending;
  assign bus.Dropped  = drop_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      data_reg <= '0;
      drop_reg <= 1'b0;
    end else if (accept) begin
      pending  <= dest;
      data_reg <= bus.InData;
      drop_reg <= is_bcast && (bus.InMask == '0);
    end else begin
      pending  <= pending & ~bus.OutReady;
      drop_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbit_stream_demux.sv
// Scoreboard bench: per-channel queues of owed words are filled on each
// accepted word and drained by a negedge monitor on every channel handshake.
module tb_nbit_stream_demux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nbit_stream_demux_if #(.SELECT_WIDTH(3), .DATA_WIDTH(32)) bus ();

  nbit_stream_demux #(.SELECT_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] q [8][$];
  logic exp_drop = 1'b0;
  logic stop_mon = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] owed();
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = (q[i].size() != 0);
    return m;
  endfunction

  // Monitor: compares the live outputs against the owed-word model.
  always @(negedge clk) begin
    if (!stop_mon) begin
      logic [7:0] om;
      logic       rdy_exp;
      om = owed();
      rdy_exp = !reset && ((om & ~bus.OutReady) == 8'h00);
      chk("outvalid", {24'h0, bus.OutValid}, {24'h0, om});
      chk("busy", {31'h0, bus.Busy}, {31'h0, |om});
      chk("inready", {31'h0, bus.InReady}, {31'h0, rdy_exp});
      chk("dropped", {31'h0, bus.Dropped}, {31'h0, exp_drop});
      if (!reset)
        for (int i = 0; i < 8; i++)
          if (bus.OutValid[i] && bus.OutReady[i] && q[i].size() != 0) begin
            chk($sformatf("data_ch%0d", i), bus.OutData, q[i][0]);
            void'(q[i].pop_front());
          end
    end
  end

  // One clock of stimulus; pushes expectations on the edge that accepts.
  task automatic step(input logic v, input logic bc, input logic [2:0] s,
                      input logic [7:0] m, input logic [31:0] d,
                      input logic [7:0] r, output logic acc);
    logic [7:0] dest;
    bus.InValid = v; bus.InBcast = bc; bus.InSel = s;
    bus.InMask = m; bus.InData = d; bus.OutReady = r;
    @(negedge clk);
    acc = v && bus.InReady && !reset;
    @(posedge clk);
    exp_drop = 1'b0;
    if (acc) begin
      dest = bc ? m : (8'b1 << s);
      for (int i = 0; i < 8; i++) if (dest[i]) q[i].push_back(d);
      exp_drop = bc && (m == 8'h00);
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] r);
    logic a;
    step(1'b0, 1'b0, 3'd0, 8'h00, 32'h0, r, a);
  endtask

  initial begin
    logic acc;
    logic [31:0] d;
    logic [2:0]  s;
    logic [7:0]  m;
    logic        bc;
    logic        v;
    bus.InValid = 0; bus.InBcast = 0; bus.InSel = 0; bus.InMask = 0;
    bus.InData = 0; bus.OutReady = 0;
    #2;
    chk("rst_outvalid", {24'h0, bus.OutValid}, 32'h0);
    chk("rst_outdata", bus.OutData, 32'h0);
    chk("rst_inready", {31'h0, bus.InReady}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("inready_after_rst", {31'h0, bus.InReady}, 32'h1);

    // Unicast to channel 5
    step(1, 0, 3'd5, 8'hFF, 32'hDEADBEEF, 8'hFF, acc);
    chk("uni_acc", {31'h0, acc}, 32'h1);
    chk("uni_ov", {24'h0, bus.OutValid}, 32'h20);
    chk("uni_data", bus.OutData, 32'hDEADBEEF);
    idle(8'hFF);
    chk("uni_busy", {31'h0, bus.Busy}, 32'h0);

    // Broadcast A5 with staggered readies
    step(1, 1, 3'd0, 8'hA5, 32'h12345678, 8'h00, acc);
    chk("bc_ov1", {24'h0, bus.OutValid}, 32'hA5);
    idle(8'h01);
    chk("bc_ov2", {24'h0, bus.OutValid}, 32'hA4);
    idle(8'h00);
    chk("bc_ov3", {24'h0, bus.OutValid}, 32'hA4);
    idle(8'h24);
    chk("bc_ov4", {24'h0, bus.OutValid}, 32'h80);
    idle(8'h00);
    idle(8'h00);
    chk("bc_ov6", {24'h0, bus.OutValid}, 32'h80);
    chk("bc_data", bus.OutData, 32'h12345678);
    chk("bc_inready_c6_low", {31'h0, bus.InReady}, 32'h0);
    idle(8'h80);
    chk("bc_ov7", {24'h0, bus.OutValid}, 32'h00);

    // Back-to-back unicast, no bubbles
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 3'(k), 8'h00, 32'hB000_0000 + k, 8'hFF, acc);
      chk($sformatf("b2b_acc%0d", k), {31'h0, acc}, 32'h1);
    end
    idle(8'hFF);

    // Broadcast with empty mask is dropped
    step(1, 1, 3'd2, 8'h00, 32'hCAFE0000, 8'hFF, acc);
    chk("drop_pulse", {31'h0, bus.Dropped}, 32'h1);
    chk("drop_ov", {24'h0, bus.OutValid}, 32'h0);
    chk("drop_inready", {31'h0, bus.InReady}, 32'h1);
    idle(8'hFF);
    chk("drop_end", {31'h0, bus.Dropped}, 32'h0);

    // Final handshakes and new load on the same edge
    step(1, 1, 3'd0, 8'h03, 32'h0303_0303, 8'h00, acc);
    step(1, 0, 3'd6, 8'hFF, 32'h6666_6666, 8'h03, acc);
    chk("stall_load_acc", {31'h0, acc}, 32'h1);
    chk("stall_load_ov", {24'h0, bus.OutValid}, 32'h40);
    chk("stall_load_data", bus.OutData, 32'h6666_6666);
    idle(8'hFF);

    // Reset mid-transfer with Pending = 0F
    step(1, 1, 3'd0, 8'h0F, 32'h0F0F_0F0F, 8'h00, acc);
    chk("pre_rst_ov", {24'h0, bus.OutValid}, 32'h0F);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) q[i].delete();
    exp_drop = 1'b0;
    #1;
    chk("midrst_ov", {24'h0, bus.OutValid}, 32'h0);
    chk("midrst_busy", {31'h0, bus.Busy}, 32'h0);
    chk("midrst_inready", {31'h0, bus.InReady}, 32'h0);
    idle(8'h00);
    reset = 1'b0;
    #1;
    chk("postrst_inready", {31'h0, bus.InReady}, 32'h1);

    // Randomized traffic; the producer holds an unaccepted word
    v = 0; bc = 0; s = 0; m = 0; d = 0;
    for (int c = 0; c < 400; c++) begin
      if (!v) begin
        v  = ($urandom_range(0, 3) != 0);
        bc = ($urandom_range(0, 2) == 0);
        s  = 3'($urandom_range(0, 7));
        m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        d  = $urandom;
      end
      step(v, bc, s, m, d, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), acc);
      if (acc) v = 0;
    end
    for (int c = 0; c < 4; c++) idle(8'hFF);
    chk("drained", {24'h0, owed()}, 32'h0);

    stop_mon = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
